// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Brief    : ID/EX stage ahead of the ALU. Valid/ready capture, operand
//            forwarding at capture and while stalled, and ALU source muxing.
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
    parameter int unsigned        XLEN     = 32,
    parameter logic [XLEN-1:0]    RESET_PC = 32'h1C00_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    // decode side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [XLEN-1:0]       in_rdata0,
    input  logic [XLEN-1:0]       in_rdata1,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [1:0]            in_src0_sel,
    input  logic [1:0]            in_src1_sel,
    input  logic [4:0]            in_alu_op,
    input  logic [4:0]            in_rd,
    input  logic                  in_rf_we,
    // write-back forwarding sources
    input  logic                  fw1_we,
    input  logic [4:0]            fw1_rd,
    input  logic [XLEN-1:0]       fw1_data,
    input  logic                  fw2_we,
    input  logic [4:0]            fw2_rd,
    input  logic [XLEN-1:0]       fw2_data,
    // ALU / EX-MEM side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       alu_src0,
    output logic [XLEN-1:0]       alu_src1,
    output logic [4:0]            alu_op,
    output logic [4:0]            out_rd,
    output logic                  out_rf_we,
    output logic [XLEN-1:0]       out_pc
);

    localparam logic [1:0]      c_sel0_pc   = 2'b01;
    localparam logic [1:0]      c_sel0_zero = 2'b10;
    localparam logic [1:0]      c_sel1_imm  = 2'b01;
    localparam logic [1:0]      c_sel1_four = 2'b10;
    localparam logic [XLEN-1:0] c_four      = XLEN'(4);

    logic                r_valid;
    logic [4:0]          r_rs1;
    logic [4:0]          r_rs2;
    logic [4:0]          r_rd;
    logic [XLEN-1:0]     r_val0;
    logic [XLEN-1:0]     r_val1;
    logic [XLEN-1:0]     r_imm;
    logic [XLEN-1:0]     r_pc;
    logic [1:0]          r_sel0;
    logic [1:0]          r_sel1;
    logic [4:0]          r_alu_op;
    logic                r_rf_we;

    logic                w_accept;
    logic                w_drain;

    // EX/MEM result is newer than MEM/WB, so it wins; x0 is hardwired and never forwarded.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] idx, input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] res;
        res = raw;
        if (idx != 5'd0 && fw1_we && fw1_rd == idx)
            res = fw1_data;
        else if (idx != 5'd0 && fw2_we && fw2_rd == idx)
            res = fw2_data;
        return res;
    endfunction

    assign in_ready = ~r_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_val0   <= '0;
            r_val1   <= '0;
            r_imm    <= '0;
            r_pc     <= RESET_PC;
            r_sel0   <= 2'b00;
            r_sel1   <= 2'b00;
            r_alu_op <= 5'b00000;
            r_rf_we  <= 1'b0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_rf_we  <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_rs1    <= in_rs1;
            r_rs2    <= in_rs2;
            r_rd     <= in_rd;
            r_val0   <= fwd(in_rs1, in_rdata0);
            r_val1   <= fwd(in_rs2, in_rdata1);
            r_imm    <= in_imm;
            r_pc     <= in_pc;
            r_sel0   <= in_src0_sel;
            r_sel1   <= in_src1_sel;
            r_alu_op <= in_alu_op;
            r_rf_we  <= in_rf_we;
        end else if (w_drain) begin
            r_valid  <= 1'b0;
        end else if (r_valid) begin
            // Stalled: keep operands coherent with results retiring behind us.
            r_val0   <= fwd(r_rs1, r_val0);
            r_val1   <= fwd(r_rs2, r_val1);
        end
    end

    always_comb begin
        alu_src0 = r_val0;
        case (r_sel0)
            c_sel0_pc:   alu_src0 = r_pc;
            c_sel0_zero: alu_src0 = '0;
            default:     alu_src0 = r_val0;
        endcase
    end

    always_comb begin
        alu_src1 = r_val1;
        case (r_sel1)
            c_sel1_imm:  alu_src1 = r_imm;
            c_sel1_four: alu_src1 = c_four;
            default:     alu_src1 = r_val1;
        endcase
    end

    assign out_valid = r_valid;
    assign alu_op    = r_alu_op;
    assign out_rd    = r_rd;
    assign out_rf_we = r_rf_we & r_valid;
    assign out_pc    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Brief    : Directed and randomized checks of ex_operand_stage against a
//            queue-based reference of the stage contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

    localparam logic [31:0] c_reset_pc = 32'h1C00_0000;

    logic        clk, rst, flush;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rdata0, in_rdata1, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_alu_op, in_rd;
    logic [1:0]  in_src0_sel, in_src1_sel;
    logic        in_rf_we;
    logic        fw1_we, fw2_we;
    logic [4:0]  fw1_rd, fw2_rd;
    logic [31:0] fw1_data, fw2_data;
    logic        out_valid, out_ready, out_rf_we;
    logic [31:0] alu_src0, alu_src1, out_pc;
    logic [4:0]  alu_op, out_rd;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd, op;
        logic [31:0] v0, v1, imm, pc;
        logic [1:0]  s0, s1;
        logic        we;
    } ent_t;

    ent_t        q[$];        // instruction held by the stage (0 or 1 entries)
    logic [31:0] drained[$];  // PCs seen leaving the stage

    ex_operand_stage #(.XLEN(32), .RESET_PC(c_reset_pc)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rdata0(in_rdata0), .in_rdata1(in_rdata1), .in_imm(in_imm),
        .in_src0_sel(in_src0_sel), .in_src1_sel(in_src1_sel),
        .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rf_we(in_rf_we),
        .fw1_we(fw1_we), .fw1_rd(fw1_rd), .fw1_data(fw1_data),
        .fw2_we(fw2_we), .fw2_rd(fw2_rd), .fw2_data(fw2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op),
        .out_rd(out_rd), .out_rf_we(out_rf_we), .out_pc(out_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] raw);
        if (idx != 0 && fw1_we && fw1_rd == idx) return fw1_data;
        if (idx != 0 && fw2_we && fw2_rd == idx) return fw2_data;
        return raw;
    endfunction

    function automatic logic [31:0] ref_src0(input ent_t e);
        if (e.s0 == 2'd1) return e.pc;
        if (e.s0 == 2'd2) return 32'd0;
        return e.v0;
    endfunction

    function automatic logic [31:0] ref_src1(input ent_t e);
        if (e.s1 == 2'd1) return e.imm;
        if (e.s1 == 2'd2) return 32'd4;
        return e.v1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0;
        in_rdata0 = 0; in_rdata1 = 0; in_imm = 0; in_src0_sel = 0; in_src1_sel = 0;
        in_alu_op = 0; in_rd = 0; in_rf_we = 0;
        fw1_we = 0; fw1_rd = 0; fw1_data = 0; fw2_we = 0; fw2_rd = 0; fw2_data = 0;
        out_ready = 1;
    endtask

    // Compare DUT against the model, advance the model by one edge, then the DUT.
    task automatic step();
        ent_t e;
        logic exp_rdy;
        #1;
        exp_rdy = (q.size() == 0) || out_ready;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            e = q[0];
            check("out_rf_we", {31'd0, out_rf_we}, {31'd0, e.we});
            check("alu_src0", alu_src0, ref_src0(e));
            check("alu_src1", alu_src1, ref_src1(e));
            check("alu_op", {27'd0, alu_op}, {27'd0, e.op});
            check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
            check("out_pc", out_pc, e.pc);
        end else begin
            check("out_rf_we_empty", {31'd0, out_rf_we}, 32'd0);
        end
        if (out_valid && out_ready) drained.push_back(out_pc);

        if (flush) begin
            q.delete();
        end else if (in_valid && exp_rdy) begin
            e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd; e.op = in_alu_op;
            e.v0 = ref_fwd(in_rs1, in_rdata0); e.v1 = ref_fwd(in_rs2, in_rdata1);
            e.imm = in_imm; e.pc = in_pc; e.s0 = in_src0_sel; e.s1 = in_src1_sel;
            e.we = in_rf_we;
            q.delete();
            q.push_back(e);
        end else if (q.size() != 0 && out_ready) begin
            q.delete();
        end else if (q.size() != 0) begin
            q[0].v0 = ref_fwd(q[0].rs1, q[0].v0);
            q[0].v1 = ref_fwd(q[0].rs2, q[0].v1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int idx;
        logic [0:5] rdy_pat;

        // Reset with an instruction offered
        idle_inputs();
        rst = 1; in_valid = 1; in_pc = 32'h444; in_rdata0 = 32'h9; in_rf_we = 1;
        @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, c_reset_pc);
        check("rst_src0", alu_src0, 32'd0);
        check("rst_src1", alu_src1, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_alu_op", {27'd0, alu_op}, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_rf_we", {31'd0, out_rf_we}, 32'd0);
        @(negedge clk);
        rst = 0;
        idle_inputs();
        step();
        check("post_rst_pc", out_pc, c_reset_pc);
        check("post_rst_src0", alu_src0, 32'd0);

        // Simple pass, register operands
        in_valid = 1; in_pc = 32'h100; in_rs1 = 1; in_rs2 = 2;
        in_rdata0 = 5; in_rdata1 = 7;
        step();
        check("pass_valid", {31'd0, out_valid}, 32'd1);
        check("pass_src0", alu_src0, 32'd5);
        check("pass_src1", alu_src1, 32'd7);
        // pc / const-4 operands
        in_src0_sel = 2'b01; in_src1_sel = 2'b10;
        step();
        check("pc_src0", alu_src0, 32'h100);
        check("four_src1", alu_src1, 32'd4);

        // Forward priority and x0 exclusion
        idle_inputs();
        in_valid = 1; in_rs1 = 3; in_rdata0 = 32'h11;
        fw1_we = 1; fw1_rd = 3; fw1_data = 32'hAA;
        fw2_we = 1; fw2_rd = 3; fw2_data = 32'hBB;
        step();
        check("fw_prio", alu_src0, 32'hAA);
        in_rs1 = 0; fw1_rd = 0; fw2_rd = 0;
        step();
        check("fw_x0", alu_src0, 32'h11);

        // Stall refresh
        idle_inputs();
        in_valid = 1; in_rs2 = 9; in_rdata1 = 32'h33; in_pc = 32'h180; in_rd = 4; in_rf_we = 1;
        step();
        in_pc = 32'h999; in_rdata1 = 32'h77; out_ready = 0;
        step();
        check("stall_rdy1", {31'd0, in_ready}, 32'd0);
        check("stall_src1_a", alu_src1, 32'h33);
        fw2_we = 1; fw2_rd = 9; fw2_data = 32'h55;
        step();
        check("stall_rdy2", {31'd0, in_ready}, 32'd0);
        check("stall_src1_b", alu_src1, 32'h55);
        fw2_we = 0;
        step();
        check("stall_src1_c", alu_src1, 32'h55);
        check("stall_pc", out_pc, 32'h180);
        in_valid = 0; out_ready = 1;
        step();

        // Stream of four with out_ready 1,0,1,1
        idle_inputs();
        drained.delete();
        rdy_pat = 6'b101111;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            out_ready = rdy_pat[c];
            in_valid = (idx < 4);
            in_pc = 32'h200 + 32'(idx) * 4;
            in_rdata0 = 32'(idx) + 32'h40;
            if (in_valid && ((q.size() == 0) || out_ready)) begin
                step();
                idx++;
            end else begin
                step();
            end
        end
        check("stream_count", 32'(drained.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < drained.size())
                check("stream_order", drained[k], 32'h200 + 32'(k) * 4);

        // Flush while holding with an instruction offered
        idle_inputs();
        in_valid = 1; in_pc = 32'h300; in_rf_we = 1;
        step();
        out_ready = 0; flush = 1; in_pc = 32'h304;
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_rf_we", {31'd0, out_rf_we}, 32'd0);
        flush = 0; in_valid = 0;
        step();
        check("flush_nocap", {31'd0, out_valid}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            flush       = ($urandom_range(0, 15) == 0);
            in_valid    = $urandom_range(0, 1);
            out_ready   = ($urandom_range(0, 2) != 0);
            in_pc       = $urandom;
            in_rs1      = 5'($urandom_range(0, 3));
            in_rs2      = 5'($urandom_range(0, 3));
            in_rdata0   = $urandom;
            in_rdata1   = $urandom;
            in_imm      = $urandom;
            in_src0_sel = 2'($urandom_range(0, 3));
            in_src1_sel = 2'($urandom_range(0, 3));
            in_alu_op   = 5'($urandom);
            in_rd       = 5'($urandom);
            in_rf_we    = $urandom_range(0, 1);
            fw1_we      = $urandom_range(0, 1);
            fw1_rd      = 5'($urandom_range(0, 3));
            fw1_data    = $urandom;
            fw2_we      = $urandom_range(0, 1);
            fw2_rd      = 5'($urandom_range(0, 3));
            fw2_data    = $urandom;
            step();
        end

        // Asynchronous reset while holding
        idle_inputs();
        in_valid = 1; in_pc = 32'h500; in_rdata0 = 32'h12;
        step();
        in_valid = 0; out_ready = 0;
        step();
        #2 rst = 1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_pc", out_pc, c_reset_pc);
        check("arst_src0", alu_src0, 32'd0);
        q.delete();
        @(negedge clk);
        rst = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
